// File: rtl/ball_mover_if.sv
// Control pulses into the ball mover and the position/status it publishes.
// Master drives frame_tick/start/pause; slave (the mover) drives everything else.
interface ball_mover_if;
  logic        frame_tick;
  logic        start;
  logic        pause;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic [11:0] radius;
  logic        bounce;
  logic        corner;
  logic        running;

  modport master (
    output frame_tick, start, pause,
    input  x_pos, y_pos, radius, bounce, corner, running
  );

  modport slave (
    input  frame_tick, start, pause,
    output x_pos, y_pos, radius, bounce, corner, running
  );
endinterface

// File: rtl/ball_mover.sv
// Bouncing-square position source: moves once per frame_tick in RUN, reflects off screen edges.
// Latency: outputs update on the edge that samples frame_tick; no backpressure, pulses are one cycle.
module ball_mover #(
  parameter int       SCREEN_W  = 640,
  parameter int       SCREEN_H  = 480,
  parameter int       RADIUS    = 8,
  parameter int       STEP      = 2,
  parameter int       X_INIT    = 320,
  parameter int       Y_INIT    = 240,
  parameter bit       X_DIR_NEG = 1'b0,
  parameter bit       Y_DIR_NEG = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  ball_mover_if.slave  bus
);

  localparam logic [12:0] XMIN   = 13'(RADIUS - 1);
  localparam logic [12:0] XMAX   = 13'(SCREEN_W - RADIUS);
  localparam logic [12:0] YMIN   = 13'(RADIUS - 1);
  localparam logic [12:0] YMAX   = 13'(SCREEN_H - RADIUS);
  localparam logic [12:0] STEP13 = 13'(STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } state_t;

  typedef struct packed {
    logic [11:0] pos;
    logic        dir;
    logic        hit;
  } axis_t;

  state_t      state;
  logic [11:0] x_q;
  logic [11:0] y_q;
  logic        dir_x;
  logic        dir_y;
  logic        bounce_q;
  logic        corner_q;
  logic        running_q;
  axis_t       nx;
  axis_t       ny;

  // 13-bit compares so pos+STEP can never wrap and fake a miss near the top of range.
  function automatic axis_t step_axis(input logic [11:0] pos, input logic dir,
                                      input logic [12:0] lo, input logic [12:0] hi);
    axis_t       r;
    logic [12:0] p;
    logic [12:0] sum;
    logic [12:0] dif;
    p   = {1'b0, pos};
    sum = p + STEP13;
    dif = p - STEP13;
    r   = '{pos: pos, dir: dir, hit: 1'b0};
    if (!dir) begin
      if (sum >= hi) r = '{pos: hi[11:0], dir: 1'b1, hit: 1'b1};
      else           r.pos = sum[11:0];
    end else begin
      if (p <= lo + STEP13) r = '{pos: lo[11:0], dir: 1'b0, hit: 1'b1};
      else                  r.pos = dif[11:0];
    end
    return r;
  endfunction

  always_comb begin
    nx = step_axis(x_q, dir_x, XMIN, XMAX);
    ny = step_axis(y_q, dir_y, YMIN, YMAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x_q       <= 12'(X_INIT);
      y_q       <= 12'(Y_INIT);
      dir_x     <= X_DIR_NEG;
      dir_y     <= Y_DIR_NEG;
      bounce_q  <= 1'b0;
      corner_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.frame_tick) begin
            x_q      <= nx.pos;
            y_q      <= ny.pos;
            dir_x    <= nx.dir;
            dir_y    <= ny.dir;
            bounce_q <= nx.hit | ny.hit;
            corner_q <= nx.hit & ny.hit;
          end
          // A pause on the tick cycle still lets this frame's move land.
          if (bus.pause) begin
            state     <= FREEZE;
            running_q <= 1'b0;
          end
        end
        FREEZE: begin
          if (bus.pause) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_pos   = x_q;
  assign bus.y_pos   = y_q;
  assign bus.radius  = 12'(RADIUS);
  assign bus.bounce  = bounce_q;
  assign bus.corner  = corner_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_ball_mover.sv
// Four mover variants share one control stream; expectations are queued per step and drained after each edge.
module tb_ball_mover;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ball_mover_if ifa ();
  ball_mover_if ifb ();
  ball_mover_if ifc ();
  ball_mover_if ifd ();

  ball_mover                                             ua (.clk(clk), .reset(reset), .bus(ifa.slave));
  ball_mover #(.X_INIT(630), .Y_INIT(240))               ub (.clk(clk), .reset(reset), .bus(ifb.slave));
  ball_mover #(.X_INIT(9),   .Y_INIT(240), .X_DIR_NEG(1'b1)) uc (.clk(clk), .reset(reset), .bus(ifc.slave));
  ball_mover #(.X_INIT(630), .Y_INIT(470))               ud (.clk(clk), .reset(reset), .bus(ifd.slave));

  typedef struct {
    string       tag;
    int          inst;
    logic [11:0] x;
    logic [11:0] y;
    logic        b;
    logic        c;
    logic        r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [26:0] observe(input int inst);
    case (inst)
      0:       return {ifa.x_pos, ifa.y_pos, ifa.bounce, ifa.corner, ifa.running};
      1:       return {ifb.x_pos, ifb.y_pos, ifb.bounce, ifb.corner, ifb.running};
      2:       return {ifc.x_pos, ifc.y_pos, ifc.bounce, ifc.corner, ifc.running};
      default: return {ifd.x_pos, ifd.y_pos, ifd.bounce, ifd.corner, ifd.running};
    endcase
  endfunction

  task automatic expect_out(input string tag, input int inst, input int x, input int y,
                            input logic b, input logic c, input logic r);
    exp_t e;
    e.tag = tag; e.inst = inst; e.x = 12'(x); e.y = 12'(y); e.b = b; e.c = c; e.r = r;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [26:0] o;
    logic [26:0] ex;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      o  = observe(e.inst);
      ex = {e.x, e.y, e.b, e.c, e.r};
      checks++;
      assert (o === ex) else begin
        failures++;
        $error("FAIL %s inst=%0d got x=%0d y=%0d b=%b c=%b r=%b want x=%0d y=%0d b=%b c=%b r=%b",
               e.tag, e.inst, o[26:15], o[14:3], o[2], o[1], o[0],
               e.x, e.y, e.b, e.c, e.r);
      end
    end
  endtask

  task automatic set_ctrl(input logic t, input logic s, input logic p);
    ifa.frame_tick = t; ifa.start = s; ifa.pause = p;
    ifb.frame_tick = t; ifb.start = s; ifb.pause = p;
    ifc.frame_tick = t; ifc.start = s; ifc.pause = p;
    ifd.frame_tick = t; ifd.start = s; ifd.pause = p;
  endtask

  // One clock with the given pulses, then check whatever was queued.
  task automatic step(input logic t, input logic s, input logic p);
    @(negedge clk);
    set_ctrl(t, s, p);
    @(posedge clk);
    #1;
    set_ctrl(1'b0, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    set_ctrl(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_out("reset_a", 0, 320, 240, 0, 0, 0);
    expect_out("reset_b", 1, 630, 240, 0, 0, 0);
    expect_out("reset_c", 2,   9, 240, 0, 0, 0);
    expect_out("reset_d", 3, 630, 470, 0, 0, 0);
    drain();
    checks++;
    assert (ifa.radius === 12'd8) else begin
      failures++;
      $error("FAIL radius got=%0d want=8", ifa.radius);
    end

    for (int i = 0; i < 3; i++) begin
      expect_out("idle_tick", 0, 320, 240, 0, 0, 0);
      step(1'b1, 1'b0, 1'b0);
    end
    expect_out("idle_pause", 0, 320, 240, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1);

    expect_out("start", 0, 320, 240, 0, 0, 1);
    step(1'b0, 1'b1, 1'b0);

    expect_out("tick1_a",     0, 322, 242, 0, 0, 1);
    expect_out("right_wall",  1, 632, 242, 1, 0, 1);
    expect_out("left_wall",   2,   7, 242, 1, 0, 1);
    expect_out("corner_hit",  3, 632, 472, 1, 1, 1);
    step(1'b1, 1'b0, 1'b0);

    expect_out("bounce_drop", 1, 632, 242, 0, 0, 1);
    expect_out("corner_drop", 3, 632, 472, 0, 0, 1);
    step(1'b0, 1'b0, 1'b0);

    expect_out("tick2_a",     0, 324, 244, 0, 0, 1);
    expect_out("right_back",  1, 630, 244, 0, 0, 1);
    expect_out("left_back",   2,   9, 244, 0, 0, 1);
    expect_out("corner_back", 3, 630, 470, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0);

    expect_out("tick_pause_a", 0, 326, 246, 0, 0, 0);
    expect_out("tick_pause_b", 1, 628, 246, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 2; i++) begin
      expect_out("frozen_tick", 0, 326, 246, 0, 0, 0);
      step(1'b1, 1'b0, 1'b0);
    end
    expect_out("frozen_start", 0, 326, 246, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0);

    expect_out("resume", 0, 326, 246, 0, 0, 1);
    step(1'b0, 1'b0, 1'b1);
    expect_out("resume_tick", 0, 328, 248, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0);
    expect_out("tick_pause2", 0, 330, 250, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1);
    expect_out("freeze_tick_pause", 0, 330, 250, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    expect_out("after_resume", 0, 332, 252, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0);

    // Reset lands between edges; outputs must clear before the next posedge.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    expect_out("async_rst_a", 0, 320, 240, 0, 0, 0);
    expect_out("async_rst_d", 3, 630, 470, 0, 0, 0);
    drain();
    @(negedge clk);
    reset = 1'b0;

    expect_out("start_with_tick", 0, 320, 240, 0, 0, 1);
    step(1'b1, 1'b1, 1'b0);
    expect_out("first_move", 0, 322, 242, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
